// File: rtl/tetris_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_seq_pkg
//  Description : Shared definitions for the instruction sequencer. Holds the
//                opcode values, the sequencer state encoding and the position
//                of the opcode field inside an instruction word. The opcode
//                field is always the top OPCODE_W bits of the 2*WIDTH-bit word.
//  Revision    : 1.0 - initial release
// ============================================================================
package tetris_seq_pkg;

    localparam int OPCODE_W = 4;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_NOP   = 4'd0;
    localparam opcode_t OP_ISSUE = 4'd1;
    localparam opcode_t OP_WAIT  = 4'd2;
    localparam opcode_t OP_JUMP  = 4'd3;
    localparam opcode_t OP_HALT  = 4'd4;
    // Every opcode above OP_HALT is illegal.

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HALTED = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    // Bit index of the opcode field LSB for a given operand width.
    function automatic int opcode_lsb(input int width);
        return 2 * width - OPCODE_W;
    endfunction

endpackage : tetris_seq_pkg
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode
//  Description : Combinational instruction decoder. Splits a 2*WIDTH-bit
//                instruction word into one-hot opcode flags and the operand.
//                Bits between the operand and the opcode field carry no
//                meaning and are ignored.
//  Ports       : i_word        instruction word
//                o_is_nop      NOP opcode
//                o_is_issue    ISSUE opcode
//                o_is_wait     WAIT opcode
//                o_is_jump     JUMP opcode
//                o_is_halt     HALT opcode
//                o_is_illegal  any opcode above HALT
//                o_operand     low WIDTH bits of the word
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_decode
    import tetris_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] i_word,
    output logic               o_is_nop,
    output logic               o_is_issue,
    output logic               o_is_wait,
    output logic               o_is_jump,
    output logic               o_is_halt,
    output logic               o_is_illegal,
    output logic [WIDTH-1:0]   o_operand
);

    localparam int c_opc_lsb = opcode_lsb(WIDTH);

    logic [OPCODE_W-1:0] w_opcode;

    assign w_opcode     = i_word[c_opc_lsb +: OPCODE_W];
    assign o_operand    = i_word[WIDTH-1:0];

    assign o_is_nop     = (w_opcode == OP_NOP);
    assign o_is_issue   = (w_opcode == OP_ISSUE);
    assign o_is_wait    = (w_opcode == OP_WAIT);
    assign o_is_jump    = (w_opcode == OP_JUMP);
    assign o_is_halt    = (w_opcode == OP_HALT);
    assign o_is_illegal = (w_opcode > OP_HALT);

    // The gap bits only exist when the word is wider than operand + opcode.
    generate
        if (c_opc_lsb > WIDTH) begin : g_gap_bits
            logic w_unused_gap;
            assign w_unused_gap = ^i_word[c_opc_lsb-1:WIDTH];
        end
    endgenerate

endmodule : instr_decode
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_sequencer
//  Description : Program sequencer for the instruction ROM. Owns the program
//                counter (driven straight onto rom_addr), fetches and decodes
//                each instruction word and issues commands to the game
//                datapath over a valid/ready handshake.
//  Ports       : clk        rising-edge clock
//                rst        asynchronous, active-low reset
//                start      pulse: (re)start the program at pc=0
//                stop       pulse: abort the program, return to IDLE
//                rom_addr   ROM address, always equal to pc
//                rom_data   ROM word, combinational read of rom_addr
//                cmd_valid  command available to datapath
//                cmd_data   command operand
//                cmd_ready  datapath accepts command
//                busy       program running (FETCH/EXEC/WAIT)
//                halted     HALT executed
//                err        illegal opcode or out-of-range jump (sticky)
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer
    import tetris_seq_pkg::*;
#(
    parameter int WIDTH               = 8,
    parameter int INSTRUCTION_NUMBERS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    output logic [WIDTH-1:0]   rom_addr,
    input  logic [2*WIDTH-1:0] rom_data,
    output logic               cmd_valid,
    output logic [WIDTH-1:0]   cmd_data,
    input  logic               cmd_ready,
    output logic               busy,
    output logic               halted,
    output logic               err
);

    localparam int             c_opc_lsb = opcode_lsb(WIDTH);
    localparam logic [WIDTH-1:0] c_last_pc = WIDTH'(INSTRUCTION_NUMBERS - 1);
    localparam logic [WIDTH:0]   c_depth   = (WIDTH+1)'(INSTRUCTION_NUMBERS);

    state_t               r_state;
    logic [WIDTH-1:0]     r_pc;
    logic [2*WIDTH-1:0]   r_instr;
    logic [WIDTH-1:0]     r_wait_cnt;
    logic                 r_cmd_valid;
    logic [WIDTH-1:0]     r_cmd_data;
    logic                 r_halted;
    logic                 r_err;
    // A stop seen while a command is outstanding, honoured after the accept.
    logic                 r_stop_pending;

    logic                 w_is_nop;
    logic                 w_is_issue;
    logic                 w_is_wait;
    logic                 w_is_jump;
    logic                 w_is_halt;
    logic                 w_is_illegal;
    logic [WIDTH-1:0]     w_operand;
    logic [WIDTH-1:0]     w_pc_inc;
    logic                 w_jump_ok;
    logic [OPCODE_W-1:0]  w_fetch_opcode;

    instr_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .i_word       (r_instr),
        .o_is_nop     (w_is_nop),
        .o_is_issue   (w_is_issue),
        .o_is_wait    (w_is_wait),
        .o_is_jump    (w_is_jump),
        .o_is_halt    (w_is_halt),
        .o_is_illegal (w_is_illegal),
        .o_operand    (w_operand)
    );

    assign w_pc_inc       = (r_pc == c_last_pc) ? '0 : r_pc + WIDTH'(1);
    assign w_jump_ok      = ({1'b0, w_operand} < c_depth);
    // ISSUE is recognised on the raw ROM word during FETCH so that cmd_valid
    // is already registered high for the first EXEC cycle.
    assign w_fetch_opcode = rom_data[c_opc_lsb +: OPCODE_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_pc           <= '0;
            r_instr        <= '0;
            r_wait_cnt     <= '0;
            r_cmd_valid    <= 1'b0;
            r_cmd_data     <= '0;
            r_halted       <= 1'b0;
            r_err          <= 1'b0;
            r_stop_pending <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        r_state <= ST_FETCH;
                        r_pc    <= '0;
                    end
                end

                ST_FETCH: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_instr <= rom_data;
                        r_state <= ST_EXEC;
                        if (w_fetch_opcode == OP_ISSUE) begin
                            r_cmd_valid <= 1'b1;
                            r_cmd_data  <= rom_data[WIDTH-1:0];
                        end
                    end
                end

                ST_EXEC: begin
                    if (w_is_issue) begin
                        // The command is never withdrawn; stop only takes
                        // effect together with the accepting handshake.
                        if (r_cmd_valid && cmd_ready) begin
                            r_cmd_valid    <= 1'b0;
                            r_pc           <= w_pc_inc;
                            r_stop_pending <= 1'b0;
                            r_state        <= (stop || r_stop_pending) ? ST_IDLE : ST_FETCH;
                        end else if (stop) begin
                            r_stop_pending <= 1'b1;
                        end
                    end else if (stop) begin
                        r_state <= ST_IDLE;
                    end else if (w_is_nop) begin
                        r_pc    <= w_pc_inc;
                        r_state <= ST_FETCH;
                    end else if (w_is_wait) begin
                        if (w_operand == '0) begin
                            r_pc    <= w_pc_inc;
                            r_state <= ST_FETCH;
                        end else begin
                            r_wait_cnt <= w_operand;
                            r_state    <= ST_WAIT;
                        end
                    end else if (w_is_jump) begin
                        if (w_jump_ok) begin
                            r_pc    <= w_operand;
                            r_state <= ST_FETCH;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_ERROR;
                        end
                    end else if (w_is_halt) begin
                        r_halted <= 1'b1;
                        r_state  <= ST_HALTED;
                    end else if (w_is_illegal) begin
                        r_err   <= 1'b1;
                        r_state <= ST_ERROR;
                    end
                end

                ST_WAIT: begin
                    // Counter holds n on the first WAIT cycle and leaves at 1,
                    // so a WAIT n spends exactly n cycles here.
                    if (stop) begin
                        r_wait_cnt <= '0;
                        r_state    <= ST_IDLE;
                    end else if (r_wait_cnt == WIDTH'(1)) begin
                        r_wait_cnt <= '0;
                        r_pc       <= w_pc_inc;
                        r_state    <= ST_FETCH;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - WIDTH'(1);
                    end
                end

                ST_HALTED, ST_ERROR: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                    end else if (start) begin
                        r_state  <= ST_FETCH;
                        r_pc     <= '0;
                        r_halted <= 1'b0;
                        r_err    <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rom_addr  = r_pc;
    assign cmd_valid = r_cmd_valid;
    assign cmd_data  = r_cmd_data;
    assign halted    = r_halted;
    assign err       = r_err;
    assign busy      = (r_state == ST_FETCH) || (r_state == ST_EXEC) || (r_state == ST_WAIT);

endmodule : instr_sequencer
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_sequencer
//  Description : Self-checking bench for instr_sequencer. Directed scenarios
//                plus random 4-word programs compared against a program
//                interpreter that predicts issued commands, final status,
//                final pc and run length.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        cmd_valid;
    logic [7:0]  cmd_data;
    logic        cmd_ready;
    logic        busy;
    logic        halted;
    logic        err;

    logic [15:0] rom_mem [DEPTH];
    logic [7:0]  obs_q [$];
    logic [7:0]  exp_q [$];

    int n_total = 0;
    int n_bad   = 0;

    instr_sequencer #(
        .WIDTH               (8),
        .INSTRUCTION_NUMBERS (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .busy      (busy),
        .halted    (halted),
        .err       (err)
    );

    assign rom_data = (rom_addr < 8'(DEPTH)) ? rom_mem[rom_addr[1:0]] : 16'h0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Program interpreter: every instruction costs a fetch and an execute
    // cycle, WAIT n adds n, ISSUE adds its stall cycles (observed separately).
    task automatic ref_model(output int cost, output int pc_end, output bit halt_end, output bit err_end);
        int          pc;
        logic [15:0] w;
        logic [3:0]  op;
        logic [7:0]  opnd;
        bit          done;
        exp_q.delete();
        cost = 0; pc = 0; halt_end = 0; err_end = 0; done = 0;
        for (int step = 0; step < 64 && !done; step++) begin
            w    = rom_mem[pc];
            op   = w[15:12];
            opnd = w[7:0];
            cost += 2;
            case (op)
                4'd0: pc = (pc + 1) % DEPTH;
                4'd1: begin exp_q.push_back(opnd); pc = (pc + 1) % DEPTH; end
                4'd2: begin cost += int'(opnd); pc = (pc + 1) % DEPTH; end
                4'd3: begin
                    if (int'(opnd) < DEPTH) pc = int'(opnd);
                    else begin err_end = 1; done = 1; end
                end
                4'd4:    begin halt_end = 1; done = 1; end
                default: begin err_end = 1; done = 1; end
            endcase
        end
        pc_end = pc;
    endtask

    // Pulse start, then run until halted/err. Edges counted from the start edge.
    // mode 0: random ready, 1: ready always high, 2: ready low for stall_n valid cycles.
    task automatic run_prog(input int mode, input int stall_n, output int edges, output int first_valid,
                            output int vcyc, output int stalls, output bit unstable);
        bit         done;
        bit         prev_hold;
        logic [7:0] prev_data;
        logic [7:0] prev_addr;
        obs_q.delete();
        edges = 0; first_valid = -1; vcyc = 0; stalls = 0; unstable = 0;
        done = 0; prev_hold = 0; prev_data = 0; prev_addr = 0;
        @(negedge clk);
        start     = 1'b1;
        cmd_ready = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            start = 1'b0;
            edges++;
            if (halted || err) begin
                done = 1;
                break;
            end
            case (mode)
                0:       cmd_ready = 1'($urandom_range(0, 1));
                1:       cmd_ready = 1'b1;
                default: cmd_ready = (vcyc >= stall_n);
            endcase
            if (cmd_valid) begin
                if (first_valid < 0) first_valid = edges;
                if (prev_hold && (cmd_data !== prev_data || rom_addr !== prev_addr)) unstable = 1;
                vcyc++;
                if (cmd_ready) obs_q.push_back(cmd_data);
                else stalls++;
            end
            prev_hold = cmd_valid && !cmd_ready;
            prev_data = cmd_data;
            prev_addr = rom_addr;
        end
        cmd_ready = 1'b0;
        if (!done) chk("run_timeout", 0, 1);
    endtask

    task automatic wait_valid(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            seen  = cmd_valid;
        end
        chk(tag, seen, 1);
    endtask

    task automatic gen_prog();
        for (int s = 0; s < DEPTH; s++) begin
            int         k;
            logic [3:0] op;
            logic [3:0] mid;
            logic [7:0] v;
            mid = 4'($urandom);
            v   = 8'($urandom);
            k   = (s == DEPTH - 1) ? $urandom_range(7, 9) : $urandom_range(0, 9);
            case (k)
                0, 1:    op = 4'd0;
                2, 3, 4: op = 4'd1;
                5, 6:    begin op = 4'd2; v = 8'($urandom_range(0, 5)); end
                7: begin
                    op = 4'd3;
                    if (s < DEPTH - 1) v = 8'($urandom_range(s + 1, DEPTH - 1));
                    else               v = 8'($urandom_range(DEPTH, 255));
                end
                8:       begin op = 4'd3; v = 8'($urandom_range(DEPTH, 255)); end
                default: op = ($urandom_range(0, 1) == 0) ? 4'd4 : 4'($urandom_range(5, 15));
            endcase
            rom_mem[s] = {op, mid, v};
        end
    endtask

    initial begin
        int edges, fv, vc, st, e_a, e_b, cost, pc_end, n;
        bit uns, h_exp, e_exp;
        logic [7:0] last;
        logic [7:0] seq [8];
        logic [7:0] seq_exp [8];

        rst = 1'b0; start = 1'b0; stop = 1'b0; cmd_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = 16'h0000;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_valid",  cmd_valid, 0);
        chk("rst_data",   cmd_data, 0);
        chk("rst_addr",   rom_addr, 0);
        chk("rst_busy",   busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_err",    err, 0);
        rst = 1'b1;

        // Start and stop together in IDLE: stop wins
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        chk("idle_start_stop", busy, 0);

        // 1: ISSUE 0x2A then HALT, ready always high
        rom_mem[0] = 16'h102A; rom_mem[1] = 16'h4000;
        run_prog(1, 0, edges, fv, vc, st, uns);
        chk("t1_first_valid", fv, 2);
        chk("t1_valid_cycles", vc, 1);
        chk("t1_ncmd", obs_q.size(), 1);
        if (obs_q.size() > 0) chk("t1_data", obs_q[0], 8'h2A);
        chk("t1_halt_edge", edges, 5);
        chk("t1_halted", halted, 1);

        // 2: stalled ISSUE 0x55, ready low for 5 valid cycles
        rom_mem[0] = 16'h1055;
        run_prog(2, 5, edges, fv, vc, st, uns);
        chk("t2_valid_cycles", vc, 6);
        chk("t2_stable", uns, 0);
        chk("t2_ncmd", obs_q.size(), 1);
        if (obs_q.size() > 0) chk("t2_data", obs_q[0], 8'h55);
        chk("t2_halt_edge", edges, 10);
        chk("t2_pc", rom_addr, 1);

        // 3: WAIT 3 vs WAIT 0
        rom_mem[0] = 16'h2003;
        run_prog(1, 0, e_a, fv, vc, st, uns);
        rom_mem[0] = 16'h2000;
        run_prog(1, 0, e_b, fv, vc, st, uns);
        chk("t3_wait0_edge", e_b, 5);
        chk("t3_wait_delta", e_a - e_b, 3);

        // 4: NOP,NOP,NOP,JUMP 1 loops through pc 0,1,2,3,1,2,3,1
        rom_mem[0] = 16'h0000; rom_mem[1] = 16'h0000; rom_mem[2] = 16'h0000; rom_mem[3] = 16'h3001;
        seq_exp[0] = 0; seq_exp[1] = 1; seq_exp[2] = 2; seq_exp[3] = 3;
        seq_exp[4] = 1; seq_exp[5] = 2; seq_exp[6] = 3; seq_exp[7] = 1;
        for (int i = 0; i < 8; i++) seq[i] = 8'hFF;
        n = 0; last = 8'hFF;
        @(negedge clk); start = 1'b1;
        for (int i = 0; i < 60 && n < 8; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 0 || rom_addr != last) begin
                seq[n] = rom_addr;
                last   = rom_addr;
                n++;
            end
        end
        for (int i = 0; i < 8; i++) chk($sformatf("t4_pc_seq%0d", i), seq[i], seq_exp[i]);
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        chk("t4_stop_busy", busy, 0);
        rom_mem[3] = 16'h3007;
        run_prog(1, 0, edges, fv, vc, st, uns);
        chk("t4_bad_jump_err", err, 1);
        chk("t4_bad_jump_pc", rom_addr, 3);
        chk("t4_bad_jump_edge", edges, 9);

        // 5: illegal opcode, then restart clears err
        rom_mem[0] = 16'h7000;
        run_prog(1, 0, edges, fv, vc, st, uns);
        chk("t5_err", err, 1);
        chk("t5_edge", edges, 3);
        chk("t5_busy", busy, 0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("t5_restart_err", err, 0);
        chk("t5_restart_pc", rom_addr, 0);
        chk("t5_restart_busy", busy, 1);
        repeat (3) @(negedge clk);

        // 6a: stop in the middle of WAIT 0xFF
        rom_mem[0] = 16'h20FF;
        @(negedge clk); start = 1'b1;
        repeat (6) begin @(negedge clk); start = 1'b0; end
        chk("t6_in_wait_busy", busy, 1);
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        chk("t6_wait_stop_busy", busy, 0);
        chk("t6_wait_stop_pc", rom_addr, 0);

        // 6b: stop during a stalled ISSUE is deferred to the handshake
        rom_mem[0] = 16'h1055; rom_mem[1] = 16'h4000;
        @(negedge clk); start = 1'b1;
        wait_valid("t6_issue_seen");
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_held_valid", cmd_valid, 1);
        chk("t6_held_data", cmd_data, 8'h55);
        chk("t6_held_busy", busy, 1);
        cmd_ready = 1'b1;
        @(negedge clk); cmd_ready = 1'b0;
        chk("t6_accept_valid", cmd_valid, 0);
        chk("t6_accept_busy", busy, 0);
        chk("t6_accept_pc", rom_addr, 1);

        // 6c: reset mid-ISSUE drops cmd_valid at once
        @(negedge clk); start = 1'b1;
        wait_valid("t6_rst_issue_seen");
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", cmd_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_pc", rom_addr, 0);
        @(negedge clk); rst = 1'b1;

        // Random programs against the interpreter
        for (int t = 0; t < 25; t++) begin
            gen_prog();
            ref_model(cost, pc_end, h_exp, e_exp);
            run_prog(0, 0, edges, fv, vc, st, uns);
            chk("rnd_ncmd", obs_q.size(), exp_q.size());
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
                chk("rnd_cmd", obs_q[i], exp_q[i]);
            chk("rnd_cycles", edges, 1 + cost + st);
            chk("rnd_halted", halted, h_exp);
            chk("rnd_err", err, e_exp);
            chk("rnd_pc", rom_addr, pc_end);
            chk("rnd_busy", busy, 0);
            chk("rnd_stable", uns, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_instr_sequencer
`default_nettype wire
